// File: rtl/l0_feeder_pkg.sv
// l0_feeder_pkg: shared types and constants for the L0 feeder block.
// The FSM state encoding, the SRAM read latency and the stall counter
// width live here so that the top and any checker agree on them.
package l0_feeder_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      FLUSH = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   // SRAM read data appears this many cycles after cen=0. The 1-entry skid
   // is sized for exactly one vector in flight, so this must stay at 1.
   localparam int RD_LAT = 1;

   // Width of the optional back-pressure stall counter.
   localparam int STALL_W = 16;

   // Saturating increment used by the stall counter.
   function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] value);
      logic [STALL_W-1:0] result;
      if (value == {STALL_W{1'b1}}) begin
         result = value;
      end else begin
         result = value + {{(STALL_W-1){1'b0}}, 1'b1};
      end
      return result;
   endfunction

endpackage

// File: rtl/l0_feeder_skid.sv
// l0_feeder_skid: one-entry holding register with a valid flag.
// Catches the SRAM vector that returns while L0 is full so it is neither
// lost nor re-read. A load wins over an unload in the same cycle, which
// lets the entry be replaced while its old contents drain.
module l0_feeder_skid #(
   parameter int width = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             unload,
   input  logic [width-1:0] din,
   output logic             valid,
   output logic [width-1:0] dout
);

   logic             valid_r;
   logic [width-1:0] data_r;

   // Hold one vector until L0 has room for it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_r <= 1'b0;
         data_r  <= {width{1'b0}};
      end else if (load) begin
         valid_r <= 1'b1;
         data_r  <= din;
      end else if (unload) begin
         valid_r <= 1'b0;
         data_r  <= data_r;
      end else begin
         valid_r <= valid_r;
         data_r  <= data_r;
      end
   end

   assign valid = valid_r;
   assign dout  = data_r;

endmodule

// File: rtl/l0_feeder.sv
// l0_feeder: streams num_vec vectors from the X-SRAM into the L0 FIFO bank,
// then issues num_vec L0 read strobes to launch the drain into the MAC array.
// Handles SRAM address generation (modulo 2^addr_w), the one-cycle SRAM read
// latency and L0 full back-pressure through a one-entry skid register.
// Optional feature: define L0_FEEDER_STALL_CNT_EN to add the stall_cnt output,
// counting FILL/FLUSH cycles that saw l0_full (saturating, cleared on start).
// Timing without back-pressure: reads start the cycle after start, each write
// follows its read by one cycle, one idle cycle separates the last write from
// the first L0 read strobe, and done arrives 2*num_vec+4 cycles after start.
module l0_feeder
   import l0_feeder_pkg::*;
#(
   parameter int row    = 8,
   parameter int bw     = 4,
   parameter int addr_w = 11,
   parameter int cnt_w  = 11
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [addr_w-1:0]   base_addr,
   input  logic [cnt_w-1:0]    num_vec,
   output logic                sram_cen,
   output logic                sram_wen,
   output logic [addr_w-1:0]   sram_addr,
   input  logic [row*bw-1:0]   sram_q,
   output logic [row*bw-1:0]   l0_in,
   output logic                l0_wr,
   output logic                l0_rd,
   input  logic                l0_full,
   output logic                busy,
   output logic                done
`ifdef L0_FEEDER_STALL_CNT_EN
   ,
   output logic [STALL_W-1:0]  stall_cnt
`endif
);

   localparam int dw = row * bw;
   localparam logic [cnt_w-1:0]  cnt_one  = {{(cnt_w-1){1'b0}}, 1'b1};
   localparam logic [addr_w-1:0] addr_one = {{(addr_w-1){1'b0}}, 1'b1};

   state_t              state_r;
   state_t              state_nxt;
   logic [cnt_w-1:0]    num_r;
   logic [cnt_w-1:0]    issued_r;
   logic [cnt_w-1:0]    written_r;
   logic [cnt_w-1:0]    drained_r;
   logic [addr_w-1:0]   addr_r;
   logic [RD_LAT-1:0]   pend_r;

   logic                accept;
   logic                issue;
   logic                drain_rd;
   logic                data_vld;
   logic                skid_load;
   logic                skid_unload;
   logic                skid_valid;
   logic [dw-1:0]       skid_data;

   assign accept   = (state_r == IDLE) && start;
   assign data_vld = pend_r[RD_LAT-1];

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt;
      end
   end

   // Next-state logic plus the per-cycle read-issue and drain-strobe decisions.
   always_comb begin
      state_nxt = state_r;
      issue     = 1'b0;
      drain_rd  = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               if (num_vec != {cnt_w{1'b0}}) begin
                  state_nxt = FILL;
               end else begin
                  state_nxt = DONE;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         FILL: begin
            // A new read only goes out when the returning vector is
            // guaranteed a home: L0 not full and the skid empty.
            if (issued_r == num_r) begin
               state_nxt = FLUSH;
            end else if (!l0_full && !skid_valid) begin
               issue = 1'b1;
            end else begin
               issue = 1'b0;
            end
         end
         FLUSH: begin
            // written==num means nothing is in flight and the skid is empty.
            if (written_r == num_r) begin
               state_nxt = DRAIN;
            end else begin
               state_nxt = FLUSH;
            end
         end
         DRAIN: begin
            if (drained_r == num_r) begin
               state_nxt = DONE;
            end else begin
               drain_rd = 1'b1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Transfer bookkeeping: sampled length, address pointer and progress counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         num_r     <= {cnt_w{1'b0}};
         issued_r  <= {cnt_w{1'b0}};
         written_r <= {cnt_w{1'b0}};
         drained_r <= {cnt_w{1'b0}};
         addr_r    <= {addr_w{1'b0}};
      end else if (accept) begin
         num_r     <= num_vec;
         issued_r  <= {cnt_w{1'b0}};
         written_r <= {cnt_w{1'b0}};
         drained_r <= {cnt_w{1'b0}};
         addr_r    <= base_addr;
      end else begin
         if (issue) begin
            issued_r <= issued_r + cnt_one;
            addr_r   <= addr_r + addr_one;
         end else begin
            issued_r <= issued_r;
            addr_r   <= addr_r;
         end
         if (l0_wr) begin
            written_r <= written_r + cnt_one;
         end else begin
            written_r <= written_r;
         end
         if (drain_rd) begin
            drained_r <= drained_r + cnt_one;
         end else begin
            drained_r <= drained_r;
         end
      end
   end

   // Track which cycle's SRAM output carries data we asked for.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_r <= {RD_LAT{1'b0}};
      end else begin
         pend_r[0] <= issue;
         for (int i = 1; i < RD_LAT; i++) begin
            pend_r[i] <= pend_r[i-1];
         end
      end
   end

   // Route returning data to L0, or park it in the skid while L0 is full.
   always_comb begin
      l0_wr       = 1'b0;
      l0_in       = {dw{1'b0}};
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      if (skid_valid) begin
         // The parked vector is older than anything on sram_q, so it goes first.
         if (!l0_full) begin
            l0_wr       = 1'b1;
            l0_in       = skid_data;
            skid_unload = 1'b1;
            skid_load   = data_vld;
         end else begin
            skid_load = 1'b0;
         end
      end else if (data_vld) begin
         if (!l0_full) begin
            l0_wr = 1'b1;
            l0_in = sram_q;
         end else begin
            skid_load = 1'b1;
         end
      end else begin
         l0_wr = 1'b0;
      end
   end

   l0_feeder_skid #(
      .width (dw)
   ) u_skid (
      .clk    (clk),
      .reset  (reset),
      .load   (skid_load),
      .unload (skid_unload),
      .din    (sram_q),
      .valid  (skid_valid),
      .dout   (skid_data)
   );

   assign sram_cen  = ~issue;
   assign sram_wen  = 1'b1;
   assign sram_addr = addr_r;
   assign l0_rd     = drain_rd;
   assign busy      = (state_r != IDLE);
   assign done      = (state_r == DONE);

`ifdef L0_FEEDER_STALL_CNT_EN
   logic [STALL_W-1:0] stall_r;

   // Count back-pressured cycles seen while moving data into L0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_r <= {STALL_W{1'b0}};
      end else if (accept) begin
         stall_r <= {STALL_W{1'b0}};
      end else if (((state_r == FILL) || (state_r == FLUSH)) && l0_full) begin
         stall_r <= sat_inc(stall_r);
      end else begin
         stall_r <= stall_r;
      end
   end

   assign stall_cnt = stall_r;
`endif

endmodule

// File: tb/tb_l0_feeder.sv
// tb_l0_feeder: scoreboard bench for l0_feeder. Expected SRAM addresses and
// L0 write data are queued when a transfer is started and popped as the DUT
// reads and writes. Define L0_FEEDER_STALL_CNT_EN to also check stall_cnt.
module tb_l0_feeder;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [10:0] base_addr;
   logic [10:0] num_vec;
   logic        sram_cen;
   logic        sram_wen;
   logic [10:0] sram_addr;
   logic [31:0] sram_q = 32'd0;
   logic [31:0] l0_in;
   logic        l0_wr;
   logic        l0_rd;
   logic        l0_full;
   logic        busy;
   logic        done;
`ifdef L0_FEEDER_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int busy_total = 0;
   int wr_total = 0;
   int rd_total = 0;
   int t0 = 0;
   int snap_busy = 0;
   int snap_wr = 0;
   int snap_rd = 0;

   logic [10:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];

   l0_feeder dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .num_vec   (num_vec),
      .sram_cen  (sram_cen),
      .sram_wen  (sram_wen),
      .sram_addr (sram_addr),
      .sram_q    (sram_q),
      .l0_in     (l0_in),
      .l0_wr     (l0_wr),
      .l0_rd     (l0_rd),
      .l0_full   (l0_full),
      .busy      (busy),
      .done      (done)
`ifdef L0_FEEDER_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_data(input logic [10:0] a);
      return {a, ~a, a[9:0]};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model: one-cycle read latency.
   always @(posedge clk) begin
      if (!sram_cen) sram_q <= mem_data(sram_addr);
   end

   // Output monitor: pops the scoreboard on every read and L0 write.
   always @(negedge clk) begin
      if (!reset) begin
         if (busy) busy_total++;
         if (!sram_cen) begin
            check_eq("read_expected", 32'(exp_addr_q.size() != 0), 32'd1);
            check_eq("sram_wen", 32'(sram_wen), 32'd1);
            check_eq("read_while_full", 32'(l0_full), 32'd0);
            if (exp_addr_q.size() != 0) check_eq("sram_addr", 32'(sram_addr), 32'(exp_addr_q.pop_front()));
         end
         if (l0_wr) begin
            wr_total++;
            check_eq("write_expected", 32'(exp_data_q.size() != 0), 32'd1);
            check_eq("wr_while_full", 32'(l0_full), 32'd0);
            if (exp_data_q.size() != 0) check_eq("l0_in", l0_in, exp_data_q.pop_front());
         end
         if (l0_rd) begin
            rd_total++;
            check_eq("rd_wr_exclusive", 32'(l0_wr), 32'd0);
         end
      end
   end

   task automatic start_xfer(input logic [10:0] b, input logic [10:0] n);
      logic [10:0] a;
      for (int i = 0; i < int'(n); i++) begin
         a = b + 11'(i);
         exp_addr_q.push_back(a);
         exp_data_q.push_back(mem_data(a));
      end
      @(posedge clk); #1;
      base_addr = b;
      num_vec   = n;
      start     = 1'b1;
      t0        = cyc;
      snap_busy = busy_total;
      snap_wr   = wr_total;
      snap_rd   = rd_total;
      @(posedge clk); #1;
      start     = 1'b0;
      base_addr = 11'($urandom);
      num_vec   = 11'($urandom);
   endtask

   task automatic wait_done(input string tag, input int exp_lat, input int n);
      logic got;
      int   lat;
      got = 1'b0;
      lat = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            lat = cyc - t0;
            break;
         end
      end
      check_eq({tag, "_done_seen"}, 32'(got), 32'd1);
      if (got) begin
         check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
         @(posedge clk); #1;
         check_eq({tag, "_busy_cycles"}, 32'(busy_total - snap_busy), 32'(lat));
         check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
         check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
         check_eq({tag, "_wr_count"}, 32'(wr_total - snap_wr), 32'(n));
         check_eq({tag, "_rd_count"}, 32'(rd_total - snap_rd), 32'(n));
         check_eq({tag, "_addr_left"}, 32'(exp_addr_q.size()), 32'd0);
         check_eq({tag, "_data_left"}, 32'(exp_data_q.size()), 32'd0);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_cen"},   32'(sram_cen),  32'd1);
      check_eq({tag, "_wen"},   32'(sram_wen),  32'd1);
      check_eq({tag, "_addr"},  32'(sram_addr), 32'd0);
      check_eq({tag, "_l0_in"}, l0_in,          32'd0);
      check_eq({tag, "_wr"},    32'(l0_wr),     32'd0);
      check_eq({tag, "_rd"},    32'(l0_rd),     32'd0);
      check_eq({tag, "_busy"},  32'(busy),      32'd0);
      check_eq({tag, "_done"},  32'(done),      32'd0);
`ifdef L0_FEEDER_STALL_CNT_EN
      check_eq({tag, "_stall"}, 32'(stall_cnt), 32'd0);
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic got;
      reset     = 1'b1;
      start     = 1'b0;
      base_addr = 11'd0;
      num_vec   = 11'd0;
      l0_full   = 1'b0;

      // Reset state.
      repeat (2) @(negedge clk);
      check_idle_outputs("reset");
      @(posedge clk); #1;
      reset = 1'b0;

      // 1: plain transfer of 4 vectors.
      start_xfer(11'h010, 11'd4);
      wait_done("t1", 12, 4);

      // 2: zero-length transfer.
      start_xfer(11'h055, 11'd0);
      wait_done("t2", 1, 0);

      // 3: L0 full on the cycle the 3rd vector returns, held 5 cycles.
      start_xfer(11'h200, 11'd6);
      fork
         wait_done("t3", 22, 6);
         begin
            repeat (3) @(posedge clk);
            #1 l0_full = 1'b1;
            repeat (5) @(posedge clk);
            #1 l0_full = 1'b0;
         end
      join
`ifdef L0_FEEDER_STALL_CNT_EN
      check_eq("t3_stall_cnt", 32'(stall_cnt), 32'd5);
`endif

      // 4: address wrap at the top of the SRAM.
      start_xfer(11'h7FE, 11'd4);
      wait_done("t4", 12, 4);
`ifdef L0_FEEDER_STALL_CNT_EN
      check_eq("t4_stall_cleared", 32'(stall_cnt), 32'd0);
`endif

      // 5: async reset mid-FILL, then a clean transfer.
      start_xfer(11'h020, 11'd8);
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (wr_total - snap_wr >= 2) begin
            got = 1'b1;
            break;
         end
      end
      check_eq("t5_two_writes", 32'(got), 32'd1);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      check_idle_outputs("t5_rst");
      @(posedge clk); #1;
      reset = 1'b0;
      exp_addr_q.delete();
      exp_data_q.delete();
      start_xfer(11'h030, 11'd5);
      wait_done("t5_clean", 14, 5);

      // 6: start pulsed during DRAIN is ignored.
      start_xfer(11'h040, 11'd4);
      fork
         wait_done("t6", 12, 4);
         begin
            repeat (7) @(posedge clk);
            #1;
            check_eq("t6_in_drain", 32'(l0_rd), 32'd1);
            base_addr = 11'h100;
            num_vec   = 11'd9;
            start     = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
         end
      join
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("t6_stays_idle", 32'(busy), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
